// File: rtl/eigen_reconstruct.sv
// Accumulates lambda*v*v^T into a symmetric double-precision matrix, one eigenpair at a time.
// Scaling takes SIZE_N cycles and the upper-triangle sweep takes SIZE_N*(SIZE_N+1)/2 cycles.
module eigen_reconstruct #(
    parameter int SIZE_N    = 8,
    parameter int MAX_PAIRS = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic                                 start,
    input  logic [63:0]                          eigenvalue,
    input  logic [SIZE_N*64-1:0]                 eigenvector,
    output logic [SIZE_N*SIZE_N*64-1:0]          matrix_out,
    output logic [$clog2(MAX_PAIRS+1)-1:0]       pair_count,
    output logic                                 busy,
    output logic                                 f,
    output logic                                 err
);

    localparam int IW = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
    localparam int PW = $clog2(MAX_PAIRS + 1);
    localparam logic [IW-1:0] LAST = IW'(SIZE_N - 1);
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {IDLE, SCALE, ACCUM, DONE} state_t;

    state_t        state;
    logic [63:0]   lambda_r;
    logic [63:0]   vec_r [SIZE_N];
    logic [63:0]   s_r   [SIZE_N];
    logic [63:0]   acc   [SIZE_N][SIZE_N];
    logic [IW-1:0] idx_i;
    logic [IW-1:0] idx_j;
    logic [63:0]   scale_prod;
    logic [63:0]   accum_prod;
    logic [63:0]   accum_sum;

    // IEEE-754 double multiply, round-to-nearest-even, subnormals handled on input and output.
    function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
        logic          sr;
        logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [105:0]  prod;
        logic [105:0]  n;
        int            p, e, sh;
        logic          sticky, rnd;
        logic [10:0]   ef;
        logic [62:0]   base;
        logic [63:0]   res;
        sr     = a[63] ^ b[63];
        a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'h0);
        b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'h0);
        a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 52'h0);
        b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 52'h0);
        a_zero = (a[62:0] == 63'h0);
        b_zero = (b[62:0] == 63'h0);
        prod   = 106'({(a[62:52] != 11'h0), a[51:0]}) * 106'({(b[62:52] != 11'h0), b[51:0]});
        p      = 0;
        for (int k = 0; k < 106; k++) begin
            if (prod[k]) p = k;
        end
        e      = ((a[62:52] == 11'h0) ? 1 : int'(a[62:52])) +
                 ((b[62:52] == 11'h0) ? 1 : int'(b[62:52])) - 1023 + (p - 104);
        n      = prod << (105 - p);
        sticky = 1'b0;
        ef     = 11'h0;
        if (e <= 0) begin
            sh = 1 - e;
            if (sh >= 106) begin
                sticky = |n;
                n      = '0;
            end else begin
                sticky = |(n & ~({106{1'b1}} << sh));
                n      = n >> sh;
            end
        end else if (e < 2047) begin
            ef = 11'(e);
        end
        rnd  = n[52] & (sticky | (|n[51:0]) | n[53]);
        base = {ef, n[104:53]} + 63'(rnd);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            res = QNAN;
        else if (a_inf || b_inf || (e >= 2047))
            res = {sr, 11'h7FF, 52'h0};
        else if (a_zero || b_zero)
            res = {sr, 63'h0};
        else
            res = {sr, base};
        return res;
    endfunction

    // IEEE-754 double add, round-to-nearest-even; operands aligned with three guard/round/sticky bits.
    function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
        logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [63:0]   x, y;
        logic [56:0]   mx, my, sum, n;
        int            ex, ey, d, p, e, k;
        logic          lost, rnd;
        logic [10:0]   ef;
        logic [62:0]   base;
        logic [63:0]   res;
        a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'h0);
        b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'h0);
        a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 52'h0);
        b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 52'h0);
        a_zero = (a[62:0] == 63'h0);
        b_zero = (b[62:0] == 63'h0);
        if (a[62:0] >= b[62:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = (x[62:52] == 11'h0) ? 1 : int'(x[62:52]);
        ey = (y[62:52] == 11'h0) ? 1 : int'(y[62:52]);
        mx = {1'b0, (x[62:52] != 11'h0), x[51:0], 3'b000};
        my = {1'b0, (y[62:52] != 11'h0), y[51:0], 3'b000};
        d  = ex - ey;
        if (d >= 57) begin
            my = (my != 57'h0) ? 57'h1 : 57'h0;
        end else begin
            lost = |(my & ~({57{1'b1}} << d));
            my   = (my >> d) | 57'(lost);
        end
        sum = (x[63] == y[63]) ? (mx + my) : (mx - my);
        p   = 0;
        for (int q = 0; q < 57; q++) begin
            if (sum[q]) p = q;
        end
        e = ex;
        if (p == 56) begin
            n = (sum >> 1) | 57'(sum[0]);
            e = e + 1;
        end else if (p < 55) begin
            k = 55 - p;
            if (k > e - 1) k = e - 1;
            n = sum << k;
            e = e - k;
        end else begin
            n = sum;
        end
        ef   = n[55] ? 11'(e) : 11'h0;
        rnd  = n[2] & (n[1] | n[0] | n[3]);
        base = {ef, n[54:3]} + 63'(rnd);
        if (a_nan || b_nan || (a_inf && b_inf && (a[63] != b[63])))
            res = QNAN;
        else if (a_inf)
            res = a;
        else if (b_inf)
            res = b;
        else if (a_zero && b_zero)
            res = {a[63] & b[63], 63'h0};
        else if (a_zero)
            res = b;
        else if (b_zero)
            res = a;
        else if (sum == 57'h0)
            res = 64'h0;
        else if (e >= 2047)
            res = {x[63], 11'h7FF, 52'h0};
        else
            res = {x[63], base};
        return res;
    endfunction

    always_comb begin
        scale_prod = fp_mul(lambda_r, vec_r[idx_i]);
        accum_prod = fp_mul(s_r[idx_i], vec_r[idx_j]);
        accum_sum  = fp_add(acc[idx_i][idx_j], accum_prod);
    end

    for (genvar gi = 0; gi < SIZE_N; gi++) begin : g_row
        for (genvar gj = 0; gj < SIZE_N; gj++) begin : g_col
            assign matrix_out[(gi*SIZE_N+gj)*64 +: 64] = acc[gi][gj];
        end
    end

    // Upper-triangle sweep writes each result to both mirror positions so the matrix stays symmetric.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lambda_r   <= 64'h0;
            idx_i      <= '0;
            idx_j      <= '0;
            pair_count <= '0;
            busy       <= 1'b0;
            f          <= 1'b0;
            err        <= 1'b0;
            for (int r = 0; r < SIZE_N; r++) begin
                vec_r[r] <= 64'h0;
                s_r[r]   <= 64'h0;
                for (int c = 0; c < SIZE_N; c++) acc[r][c] <= 64'h0;
            end
        end else begin
            case (state)
                IDLE: begin
                    f <= 1'b0;
                    if (clear) begin
                        pair_count <= '0;
                        err        <= 1'b0;
                        for (int r = 0; r < SIZE_N; r++)
                            for (int c = 0; c < SIZE_N; c++) acc[r][c] <= 64'h0;
                    end else if (start) begin
                        if (pair_count == PW'(MAX_PAIRS)) begin
                            err <= 1'b1;
                        end else begin
                            lambda_r <= eigenvalue;
                            for (int r = 0; r < SIZE_N; r++) vec_r[r] <= eigenvector[r*64 +: 64];
                            idx_i <= '0;
                            idx_j <= '0;
                            busy  <= 1'b1;
                            state <= SCALE;
                        end
                    end
                end
                SCALE: begin
                    s_r[idx_i] <= scale_prod;
                    if (idx_i == LAST) begin
                        idx_i <= '0;
                        idx_j <= '0;
                        state <= ACCUM;
                    end else begin
                        idx_i <= idx_i + 1'b1;
                    end
                end
                ACCUM: begin
                    acc[idx_i][idx_j] <= accum_sum;
                    acc[idx_j][idx_i] <= accum_sum;
                    if (idx_j == LAST) begin
                        if (idx_i == LAST) begin
                            idx_i <= '0;
                            idx_j <= '0;
                            f     <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx_i <= idx_i + 1'b1;
                            idx_j <= idx_i + 1'b1;
                        end
                    end else begin
                        idx_j <= idx_j + 1'b1;
                    end
                end
                DONE: begin
                    f          <= 1'b0;
                    busy       <= 1'b0;
                    pair_count <= pair_count + PW'(1);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eigen_reconstruct.sv
// Bench for eigen_reconstruct: an 8x8 instance and a 4x4 instance limited to two pairs.
// A queue of expected latency/pair-count records is matched against each done pulse.
module tb_eigen_reconstruct;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          clear8, start8, busy8, f8, err8;
    logic [63:0]   lam8;
    logic [511:0]  vec8;
    logic [4095:0] mat8;
    logic [3:0]    pc8;

    logic          clear4, start4, busy4, f4, err4;
    logic [63:0]   lam4;
    logic [255:0]  vec4;
    logic [1023:0] mat4;
    logic [1:0]    pc4;

    eigen_reconstruct #(.SIZE_N(8), .MAX_PAIRS(8)) dut8 (
        .clk(clk), .rst(rst), .clear(clear8), .start(start8), .eigenvalue(lam8),
        .eigenvector(vec8), .matrix_out(mat8), .pair_count(pc8), .busy(busy8), .f(f8), .err(err8));

    eigen_reconstruct #(.SIZE_N(4), .MAX_PAIRS(2)) dut4 (
        .clk(clk), .rst(rst), .clear(clear4), .start(start4), .eigenvalue(lam4),
        .eigenvector(vec4), .matrix_out(mat4), .pair_count(pc4), .busy(busy4), .f(f4), .err(err4));

    typedef struct {int latency; int pc_after; int sel;} exp_t;
    typedef struct {real lam; int ka; real va; int kb; real vb; int exp_pc;} vec_t;

    exp_t sb[$];
    vec_t tbl[6];
    int   checks = 0;
    int   failures = 0;
    int   pulses8 = 0;
    int   pulses4 = 0;
    real  model8[8][8];
    real  model4[4][4];
    real  mv[8];

    always @(negedge clk) begin
        if (f8) pulses8++;
        if (f4) pulses4++;
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_vec(input int ka, input real va, input int kb, input real vb);
        for (int k = 0; k < 8; k++) mv[k] = 0.0;
        if (ka >= 0) mv[ka] = va;
        if (kb >= 0) mv[kb] = vb;
    endtask

    function automatic logic [511:0] vec_from_model();
        logic [511:0] v;
        for (int k = 0; k < 8; k++) v[k*64 +: 64] = $realtobits(mv[k]);
        return v;
    endfunction

    task automatic model8_reset();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) model8[i][j] = 0.0;
    endtask

    task automatic model8_pair(input real lam);
        real s, m;
        for (int i = 0; i < 8; i++) begin
            s = lam * mv[i];
            for (int j = i; j < 8; j++) begin
                m = model8[i][j] + s * mv[j];
                model8[i][j] = m;
                model8[j][i] = m;
            end
        end
    endtask

    task automatic check_matrix8(input string name);
        logic [63:0] a, e;
        int bad = -1;
        checks++;
        for (int i = 0; i < 64; i++) begin
            a = mat8[i*64 +: 64];
            e = $realtobits(model8[i/8][i%8]);
            if (bad < 0 && a !== e) bad = i;
        end
        if (bad >= 0) begin
            failures++;
            $display("[TB] FAIL %s: element [%0d][%0d] got %0h expected %0h", name, bad/8, bad%8,
                     mat8[bad*64 +: 64], $realtobits(model8[bad/8][bad%8]));
        end
    endtask

    task automatic check_matrix4(input string name);
        int bad = -1;
        checks++;
        for (int i = 0; i < 16; i++)
            if (bad < 0 && mat4[i*64 +: 64] !== $realtobits(model4[i/4][i%4])) bad = i;
        if (bad >= 0) begin
            failures++;
            $display("[TB] FAIL %s: element [%0d][%0d] got %0h expected %0h", name, bad/4, bad%4,
                     mat4[bad*64 +: 64], $realtobits(model4[bad/4][bad%4]));
        end
    endtask

    // One-cycle start; inputs are scrambled right after the capture edge.
    task automatic apply_stimulus(input int sel, input real lam, input logic [511:0] v,
                                  input int exp_lat, input int exp_pc, input bit expect_done);
        if (sel == 8) begin
            lam8 = $realtobits(lam); vec8 = v; start8 = 1'b1;
            tick(1);
            start8 = 1'b0; lam8 = $realtobits(7.0); vec8 = {8{$realtobits(1.0)}};
        end else begin
            lam4 = $realtobits(lam); vec4 = v[255:0]; start4 = 1'b1;
            tick(1);
            start4 = 1'b0; lam4 = $realtobits(7.0); vec4 = {4{$realtobits(1.0)}};
        end
        if (expect_done) sb.push_back('{exp_lat, exp_pc, sel});
    endtask

    task automatic check_output(input int sel, input int offset);
        exp_t e;
        int   cnt = offset;
        bit   seen = 1'b0;
        while (!seen && cnt < 300) begin
            tick(1);
            cnt++;
            seen = (sel == 8) ? f8 : f4;
        end
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL scoreboard_empty: got done pulse %0d expected queued entry", seen);
            return;
        end
        e = sb.pop_front();
        if (!seen) begin
            checks++; failures++;
            $display("[TB] FAIL done_timeout: got no pulse after %0d cycles expected %0d", cnt, e.latency);
            return;
        end
        check_val($sformatf("latency_sel%0d", sel), 64'(cnt), 64'(e.latency));
        tick(1);
        check_val("f_one_cycle", 64'((sel == 8) ? f8 : f4), 64'h0);
        check_val("pair_count", 64'((sel == 8) ? int'(pc8) : int'(pc4)), 64'(e.pc_after));
        check_val("busy_after_done", 64'((sel == 8) ? busy8 : busy4), 64'h0);
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        clear8 = 0; start8 = 0; lam8 = '0; vec8 = '0;
        clear4 = 0; start4 = 0; lam4 = '0; vec4 = '0;
        tick(3);
        model8_reset();
        check_val("reset_busy", 64'(busy8), 64'h0);
        check_val("reset_f", 64'(f8), 64'h0);
        check_val("reset_err", 64'(err8), 64'h0);
        check_val("reset_pc", 64'(pc8), 64'h0);
        check_matrix8("reset_matrix");
        rst = 1'b0;
        tick(1);

        // Single pair lambda=2, v=e0, then lambda=3, v=e1.
        set_vec(0, 1.0, -1, 0.0);
        model8_pair(2.0);
        apply_stimulus(8, 2.0, vec_from_model(), 44, 1, 1'b1);
        check_output(8, 0);
        check_matrix8("pair_e0");
        set_vec(1, 1.0, -1, 0.0);
        model8_pair(3.0);
        apply_stimulus(8, 3.0, vec_from_model(), 44, 2, 1'b1);
        check_output(8, 0);
        check_matrix8("pair_e1");
        check_val("two_pulses", 64'(pulses8), 64'd2);

        // clear during SCALE and start during ACCUM are ignored.
        clear8 = 1'b1; tick(1); clear8 = 1'b0;
        model8_reset();
        check_matrix8("clear_matrix");
        check_val("clear_pc", 64'(pc8), 64'h0);
        p0 = pulses8;
        set_vec(0, 1.0, -1, 0.0);
        model8_pair(2.0);
        apply_stimulus(8, 2.0, vec_from_model(), 44, 1, 1'b1);
        tick(3);
        clear8 = 1'b1; tick(1); clear8 = 1'b0;
        tick(10);
        start8 = 1'b1; lam8 = $realtobits(5.0); vec8 = {8{$realtobits(1.0)}};
        tick(1);
        start8 = 1'b0;
        check_output(8, 15);
        check_matrix8("ignored_clear_start");
        tick(60);
        check_val("single_pulse", 64'(pulses8 - p0), 64'd1);

        // Accumulating table, including a zero eigenvalue and mixed exponents.
        tbl[0] = '{2.0,   0, 1.0,   -1, 0.0,    2};
        tbl[1] = '{-1.5,  2, 0.5,    5, 2.0,    3};
        tbl[2] = '{0.0,   3, -0.5,   4, 1.0,    4};
        tbl[3] = '{3.0,   3, 1.25,   6, -0.375, 5};
        tbl[4] = '{0.5,   2, -1.0,   7, 4.0,    6};
        tbl[5] = '{1.0,   0, 0.25,   2, -0.75,  7};
        for (int t = 0; t < 6; t++) begin
            set_vec(tbl[t].ka, tbl[t].va, tbl[t].kb, tbl[t].vb);
            model8_pair(tbl[t].lam);
            apply_stimulus(8, tbl[t].lam, vec_from_model(), 44, tbl[t].exp_pc, 1'b1);
            check_output(8, 0);
            check_matrix8($sformatf("table_%0d", t));
        end
        check_val("table_err", 64'(err8), 64'h0);

        // 4x4 instance: all-0.5 vector, then capacity limit of two pairs.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) model4[i][j] = 0.25;
        apply_stimulus(4, 1.0, {256'h0, {4{$realtobits(0.5)}}}, 14, 1, 1'b1);
        check_output(4, 0);
        check_matrix4("quarter_matrix");
        check_val("sym_0_3", mat4[3*64 +: 64], mat4[12*64 +: 64]);
        check_val("sym_1_2", mat4[6*64 +: 64], mat4[9*64 +: 64]);
        model4[3][3] = 2.25;
        apply_stimulus(4, 2.0, {256'h0, $realtobits(1.0), 192'h0}, 14, 2, 1'b1);
        check_output(4, 0);
        check_matrix4("second_pair4");
        p0 = pulses4;
        apply_stimulus(4, 5.0, {256'h0, {4{$realtobits(1.0)}}}, 0, 0, 1'b0);
        check_val("overflow_err", 64'(err4), 64'h1);
        tick(30);
        check_val("overflow_no_pulse", 64'(pulses4 - p0), 64'h0);
        check_val("overflow_pc", 64'(pc4), 64'd2);
        check_val("overflow_busy", 64'(busy4), 64'h0);
        check_matrix4("overflow_matrix");
        clear4 = 1'b1; tick(1); clear4 = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) model4[i][j] = 0.0;
        check_matrix4("clear4_matrix");
        check_val("clear4_pc", 64'(pc4), 64'h0);
        check_val("clear4_err", 64'(err4), 64'h0);

        // Reset during ACCUM cycle 10 aborts the pair.
        p0 = pulses8;
        set_vec(0, 1.0, -1, 0.0);
        apply_stimulus(8, 2.0, vec_from_model(), 0, 0, 1'b0);
        tick(18);
        rst = 1'b1;
        #1;
        model8_reset();
        check_val("abort_busy", 64'(busy8), 64'h0);
        check_val("abort_f", 64'(f8), 64'h0);
        check_val("abort_pc", 64'(pc8), 64'h0);
        check_matrix8("abort_matrix");
        tick(2);
        rst = 1'b0;
        tick(60);
        check_val("abort_no_pulse", 64'(pulses8 - p0), 64'h0);
        check_val("abort_idle", 64'(busy8), 64'h0);
        check_matrix8("abort_matrix_later");
        check_val("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eigen_reconstruct.md
EIGEN_RECONSTRUCT -- requirements
Module: eigen_reconstruct

Interface
REQ-001 SHALL have parameter SIZE_N, default 8, meaning matrix dimension and eigenvector length.
REQ-002 SHALL have parameter MAX_PAIRS, default 8, meaning maximum eigenpairs accumulated between clears.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clear  input  1  zero accumulator matrix and pair count.
REQ-006 SHALL have port start  input  1  request to accumulate one eigenpair.
REQ-007 SHALL have port eigenvalue  input  double (64-bit fp_double)  lambda of the pair.
REQ-008 SHALL have port eigenvector  input  double[SIZE_N][1]  v of the pair.
REQ-009 SHALL have port matrix_out  output  double[SIZE_N][SIZE_N]  accumulated sum of lambda*v*v^T.
REQ-010 SHALL have port pair_count  output  $clog2(MAX_PAIRS+1) bits  number of pairs accumulated.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port f  output  1  one-cycle done pulse.
REQ-013 SHALL have port err  output  1  sticky overflow flag.

Function
REQ-014 SHALL implement states IDLE, SCALE, ACCUM, DONE; no other reachable state.
REQ-015 In IDLE with start=1, clear=0, pair_count<MAX_PAIRS: SHALL capture eigenvalue and eigenvector into internal registers and go to SCALE.
REQ-016 Captured copies only SHALL be used; input changes after the capture edge have no effect.
REQ-017 SCALE: SHALL compute s[i]=lambda*v[i], one index per cycle, i=0..SIZE_N-1, then go to ACCUM; SCALE lasts SIZE_N cycles.
REQ-018 ACCUM: SHALL visit (i,j) with i<=j in row-major order, one per cycle, computing m=acc[i][j]+s[i]*v[j] with fp_double multiply and add.
REQ-019 ACCUM: SHALL write m to acc[i][j] and to acc[j][i] in the same cycle; ACCUM lasts SIZE_N*(SIZE_N+1)/2 cycles, then go to DONE.
REQ-020 DONE: SHALL hold f=1 for exactly one cycle, increment pair_count by 1, then return to IDLE.
REQ-021 Latency: f SHALL be high in the cycle beginning SIZE_N+SIZE_N*(SIZE_N+1)/2 edges after the capture edge (44 for SIZE_N=8).
REQ-022 matrix_out SHALL be driven directly from acc; mid-operation values are not guaranteed consistent and are valid only while busy=0.
REQ-023 start while busy=1 SHALL be ignored and SHALL not be queued.
REQ-024 clear in IDLE SHALL zero all acc elements, zero pair_count and clear err on the next edge.
REQ-025 clear while busy=1 SHALL be ignored.
REQ-026 clear and start both high in IDLE: clear SHALL win; start ignored, no pair captured.
REQ-027 start in IDLE with pair_count==MAX_PAIRS: SHALL set err=1, stay in IDLE, leave acc and pair_count unchanged, and produce no f pulse.
REQ-028 eigenvalue of +0.0 SHALL run the full sequence; acc unchanged numerically, pair_count still increments.
REQ-029 No rounding or normalisation beyond the fp_double operators SHALL be applied; v is not renormalised.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, acc to all +0.0, pair_count=0, busy=0, f=0, err=0, internal captured registers and counters to 0.
REQ-031 rst asserted mid-SCALE or mid-ACCUM SHALL abort the pair with no f pulse, with all state as in REQ-030.

Verification
REQ-032 SIZE_N=8, lambda=2.0, v=e0, start one cycle -> f high 44 cycles after capture; matrix_out[0][0]=2.0, all others 0.0, pair_count=1.
REQ-033 Pair lambda=2.0,v=e0 then lambda=3.0,v=e1 -> diagonal 2.0, 3.0, rest 0.0; pair_count=2; exactly two f pulses.
REQ-034 SIZE_N=4, lambda=1.0, v=all 0.5 -> all 16 elements 0.25 and matrix_out symmetric; f after 4+10=14 cycles.
REQ-035 start re-pulsed during ACCUM, and clear pulsed during SCALE -> both ignored; single f pulse; result as REQ-032.
REQ-036 MAX_PAIRS=2, three starts -> third sets err=1, no f, pair_count=2; then clear -> acc zero, pair_count=0, err=0.
REQ-037 rst asserted at ACCUM cycle 10 -> f never pulses, matrix_out all 0.0, busy=0, pair_count=0.
